fft_radix2_iter: RTL and testbench

//  Parametrised N-point radix-2 DIT FFT/IFFT with serial I/O; successor to the fixed 4-point 8-bit core.

---
 rtl/fft_pkg.sv | 55 +++++
 rtl/fft_butterfly.sv | 43 ++++
 rtl/fft_radix2_iter.sv | 107 ++++++++++
 tb/tb_fft_radix2_iter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the iterative radix-2 FFT: FSM states,
// bit reversal, twiddle ROM and saturation.
package fft_pkg;

  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

  typedef struct packed {
    logic signed [15:0] c;
    logic signed [15:0] s;
  } twid_t;

  // Reference precision of the quarter-wave table; supports TW up to 17.
  localparam int TW_REF_FRAC = 16;

  function automatic int bitrev(input int idx, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((idx >> i) & 1);
    return r;
  endfunction

  // cos(2*pi*a/16) for a = 0..4, scaled by 2**16 and rounded
  function automatic int qcos(input int a);
    case (a)
      0:       return 65536;
      1:       return 60547;
      2:       return 46341;
      3:       return 25080;
      default: return 0;
    endcase
  endfunction

  // {cos, sin} of 2*pi*k/n in Q2.(tw_w-2), round to nearest; k < n/2.
  function automatic twid_t tw(input int k, input int n, input int tw_w);
    int a, c, s, sh;
    twid_t r;
    a  = k * (16 / n);
    c  = (a <= 4) ? qcos(a) : -qcos(8 - a);
    s  = (a <= 4) ? qcos(4 - a) : qcos(a - 4);
    sh = TW_REF_FRAC - (tw_w - 2);
    c  = (c + (1 << (sh - 1))) >>> sh;
    s  = (s + (1 << (sh - 1))) >>> sh;
    r.c = 16'(c);
    r.s = 16'(s);
    return r;
  endfunction

  function automatic int sat(input int v, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 DIT butterfly with 1/2 scaling and saturation:
// A' = sat((A + B*W) >>> 1), B' = sat((A - B*W) >>> 1).
module fft_butterfly import fft_pkg::*; #(
  parameter int W  = 8,
  parameter int TW = 8
) (
  input  logic signed [W-1:0]  a_re,
  input  logic signed [W-1:0]  a_im,
  input  logic signed [W-1:0]  b_re,
  input  logic signed [W-1:0]  b_im,
  input  logic signed [TW-1:0] w_re,
  input  logic signed [TW-1:0] w_im,
  output logic signed [W-1:0]  ao_re,
  output logic signed [W-1:0]  ao_im,
  output logic signed [W-1:0]  bo_re,
  output logic signed [W-1:0]  bo_im
);
  localparam int PW = W + TW + 1;

  logic signed [PW-1:0] p_re_full, p_im_full;
  logic signed [W+1:0]  p_re, p_im, a_re_x, a_im_x;
  logic signed [W+1:0]  sa_re, sa_im, sb_re, sb_im;

  assign p_re_full = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
  assign p_im_full = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);

  // |P| <= 2**W after dropping the twiddle fraction, so W+2 bits hold A+-P
  assign p_re   = (W+2)'(p_re_full >>> (TW - 2));
  assign p_im   = (W+2)'(p_im_full >>> (TW - 2));
  assign a_re_x = (W+2)'(a_re);
  assign a_im_x = (W+2)'(a_im);

  assign sa_re = a_re_x + p_re;
  assign sa_im = a_im_x + p_im;
  assign sb_re = a_re_x - p_re;
  assign sb_im = a_im_x - p_im;

  assign ao_re = W'(sat(int'(sa_re >>> 1), W));
  assign ao_im = W'(sat(int'(sa_im >>> 1), W));
  assign bo_re = W'(sat(int'(sb_re >>> 1), W));
  assign bo_im = W'(sat(int'(sb_im >>> 1), W));

endmodule

// File: rtl/fft_radix2_iter.sv
// N-point radix-2 DIT FFT/IFFT, serial in / serial out, one shared butterfly
// running log2(N) in-place stages over a bit-reversed register buffer.
module fft_radix2_iter import fft_pkg::*; #(
  parameter int LOG2N = 2,
  parameter int W     = 8,
  parameter int TW    = 8
) (
  input  logic                fastclock,
  input  logic                n_rst,
  input  logic                readyin,
  input  logic signed [W-1:0] x,
  input  logic                inv,
  output logic                busy,
  output logic                valid_out,
  output logic [LOG2N-1:0]    out_idx,
  output logic signed [W-1:0] y_re,
  output logic signed [W-1:0] y_im,
  output logic                overrun
);
  localparam int N  = 1 << LOG2N;
  localparam int SW = $clog2(LOG2N);

  state_t state, state_nx;
  logic [LOG2N-1:0]        cnt;
  logic [SW-1:0]           stage;
  logic                    inv_q;
  logic [N-1:0][W-1:0]     mem_re, mem_im;

  logic [LOG2N-1:0]        b_idx, span, j_idx, idx_a, idx_b, tw_k;
  logic                    last_b, last_stage;
  twid_t                   tw_val;
  logic signed [TW-1:0]    w_re, w_im;
  logic signed [W-1:0]     ao_re, ao_im, bo_re, bo_im;

  // Butterfly addressing: group = b >> s, A = group*2*span + (b mod span), B = A + span
  assign b_idx      = {1'b0, cnt[LOG2N-2:0]};
  assign span       = LOG2N'(1) << stage;
  assign j_idx      = b_idx & (span - 1'b1);
  assign idx_a      = (((b_idx >> stage) << stage) << 1) | j_idx;
  assign idx_b      = idx_a | span;
  assign tw_k       = j_idx << (SW'(LOG2N - 1) - stage);
  assign last_b     = (cnt[LOG2N-2:0] == '1);
  assign last_stage = (stage == SW'(LOG2N - 1));

  assign tw_val = tw(int'(tw_k), N, TW);
  assign w_re   = TW'(tw_val.c);
  assign w_im   = inv_q ? TW'(tw_val.s) : TW'(-tw_val.s);

  fft_butterfly #(.W(W), .TW(TW)) u_bfly (
    .a_re (mem_re[idx_a]), .a_im (mem_im[idx_a]),
    .b_re (mem_re[idx_b]), .b_im (mem_im[idx_b]),
    .w_re (w_re),          .w_im (w_im),
    .ao_re(ao_re),         .ao_im(ao_im),
    .bo_re(bo_re),         .bo_im(bo_im)
  );

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (readyin && cnt == LOG2N'(N - 1)) state_nx = COMPUTE;
      COMPUTE: if (last_b && last_stage)            state_nx = UNLOAD;
      UNLOAD:  if (cnt == LOG2N'(N - 1))            state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge fastclock or negedge n_rst) begin
    if (!n_rst) begin
      state   <= LOAD;
      cnt     <= '0;
      stage   <= '0;
      inv_q   <= 1'b0;
      overrun <= 1'b0;
      mem_re  <= '0;
      mem_im  <= '0;
    end else begin
      state <= state_nx;
      if (readyin && busy) overrun <= 1'b1;
      case (state)
        LOAD: if (readyin) begin
          mem_re[LOG2N'(bitrev(int'(cnt), LOG2N))] <= x;
          mem_im[LOG2N'(bitrev(int'(cnt), LOG2N))] <= '0;
          if (cnt == '0) inv_q <= inv;
          cnt <= cnt + 1'b1;
        end
        COMPUTE: begin
          mem_re[idx_a] <= ao_re;
          mem_im[idx_a] <= ao_im;
          mem_re[idx_b] <= bo_re;
          mem_im[idx_b] <= bo_im;
          cnt <= last_b ? '0 : cnt + 1'b1;
          if (last_b) stage <= last_stage ? '0 : stage + 1'b1;
        end
        UNLOAD:  cnt <= cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  // Outputs decode straight from state so reset clears them without a clock
  assign busy      = (state != LOAD);
  assign valid_out = (state == UNLOAD);
  assign out_idx   = valid_out ? cnt : '0;
  assign y_re      = valid_out ? mem_re[cnt] : '0;
  assign y_im      = valid_out ? mem_im[cnt] : '0;

endmodule

// File: tb/tb_fft_radix2_iter.sv
// Bench for fft_radix2_iter: a 4-point and an 8-point instance, table-driven
// frames with a bin scoreboard, plus overrun and mid-frame reset sequences.
module tb_fft_radix2_iter;

  typedef struct { int idx; int re; int im; } bin_t;
  typedef struct { int x[4]; bit inv; int er[4]; int ei[4]; } vec_t;

  logic clk = 1'b0;
  logic n_rst;
  logic rdy4, inv4, rdy8;
  logic signed [7:0] x4, x8;
  logic busy4, valid4, ovr4, busy8, valid8, ovr8;
  logic [1:0] idx4;
  logic [2:0] idx8;
  logic signed [7:0] y4_re, y4_im, y8_re, y8_im;

  int tests = 0, fails = 0;
  int comp4 = 0, vrun4 = 0, vrun8 = 0;
  bin_t q4[$], q8[$];
  vec_t vt[7];

  always #5 clk = ~clk;

  fft_radix2_iter #(.LOG2N(2), .W(8), .TW(8)) dut4 (
    .fastclock(clk), .n_rst(n_rst), .readyin(rdy4), .x(x4), .inv(inv4),
    .busy(busy4), .valid_out(valid4), .out_idx(idx4),
    .y_re(y4_re), .y_im(y4_im), .overrun(ovr4));

  fft_radix2_iter #(.LOG2N(3), .W(8), .TW(8)) dut8 (
    .fastclock(clk), .n_rst(n_rst), .readyin(rdy8), .x(x8), .inv(1'b0),
    .busy(busy8), .valid_out(valid8), .out_idx(idx8),
    .y_re(y8_re), .y_im(y8_im), .overrun(ovr8));

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic pop_cmp(input string tag, inout bin_t q[$], input int idx, input int re, input int im);
    bin_t e;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL %s_unexpected_bin: got bin %0d, required no output", tag, idx);
    end else begin
      e = q.pop_front();
      check($sformatf("%s_idx", tag), idx, e.idx);
      check($sformatf("%s_bin%0d_re", tag, e.idx), re, e.re);
      check($sformatf("%s_bin%0d_im", tag, e.idx), im, e.im);
    end
  endtask

  // Sampled mid-cycle on the falling edge
  task automatic monitor();
    if (!n_rst) begin
      comp4 = 0; vrun4 = 0; vrun8 = 0;
    end else begin
      if (valid4) begin
        if (vrun4 == 0) check("d4_compute_cycles", comp4, 4);
        vrun4++;
        pop_cmp("d4", q4, int'(idx4), int'(y4_re), int'(y4_im));
      end else if (vrun4 != 0) begin
        check("d4_valid_cycles", vrun4, 4);
        check("d4_y_re_idle", int'(y4_re), 0);
        check("d4_y_im_idle", int'(y4_im), 0);
        vrun4 = 0; comp4 = 0;
      end else if (busy4) comp4++;
      if (valid8) begin
        vrun8++;
        pop_cmp("d8", q8, int'(idx8), int'(y8_re), int'(y8_im));
      end else if (vrun8 != 0) begin
        check("d8_valid_cycles", vrun8, 8);
        vrun8 = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input int er[4], input int ei[4]);
    for (int k = 0; k < 4; k++) q4.push_back('{k, er[k], ei[k]});
  endtask

  task automatic push8(input int er[8], input int ei[8]);
    for (int k = 0; k < 8; k++) q8.push_back('{k, er[k], ei[k]});
  endtask

  task automatic load4(input int s[4], input bit iv);
    for (int i = 0; i < 4; i++) begin
      rdy4 = 1'b1; x4 = 8'(s[i]); inv4 = iv;
      tick();
    end
    rdy4 = 1'b0; x4 = '0;
  endtask

  task automatic load8(input int s[8]);
    for (int i = 0; i < 8; i++) begin
      rdy8 = 1'b1; x8 = 8'(s[i]);
      tick();
    end
    rdy8 = 1'b0; x8 = '0;
  endtask

  // readyin stays high; while busy a junk sample is offered and must be dropped
  task automatic load4_hold(input int s[4]);
    int i;
    logic b;
    i = 0;
    for (int c = 0; c < 40 && i < 4; c++) begin
      b = busy4;
      rdy4 = 1'b1; inv4 = 1'b0;
      x4 = b ? 8'sd100 : 8'(s[i]);
      tick();
      if (!b) i++;
    end
    if (i < 4) check("d4_hold_load_timeout", i, 4);
  endtask

  task automatic drain();
    for (int c = 0; c < 60 && (q4.size() != 0 || q8.size() != 0 || vrun4 != 0 || vrun8 != 0); c++)
      tick();
    check("drain_pending_bins", q4.size() + q8.size(), 0);
  endtask

  initial begin
    int imp[4], dc[4], e16[4], zero4[4], e_dc[4];
    int s127[8], e127[8], zero8[8], dimp[8], edr[8], edi[8];

    vt[0] = '{x: '{64, 0, 0, 0},    inv: 1'b0, er: '{16, 16, 16, 16},  ei: '{0, 0, 0, 0}};
    vt[1] = '{x: '{32, 32, 32, 32}, inv: 1'b0, er: '{32, 0, 0, 0},     ei: '{0, 0, 0, 0}};
    vt[2] = '{x: '{0, 32, 0, -32},  inv: 1'b0, er: '{0, 0, 0, 0},      ei: '{0, -16, 0, 16}};
    vt[3] = '{x: '{0, 32, 0, -32},  inv: 1'b1, er: '{0, 0, 0, 0},      ei: '{0, 16, 0, -16}};
    vt[4] = '{x: '{32, -32, 32, -32}, inv: 1'b0, er: '{0, 0, 32, 0},   ei: '{0, 0, 0, 0}};
    vt[5] = '{x: '{-64, 0, 0, 0},   inv: 1'b0, er: '{-16, -16, -16, -16}, ei: '{0, 0, 0, 0}};
    vt[6] = '{x: '{16, 0, -16, 0},  inv: 1'b0, er: '{0, 8, 0, 8},      ei: '{0, 0, 0, 0}};

    imp = '{64, 0, 0, 0};    e16 = '{16, 16, 16, 16}; zero4 = '{0, 0, 0, 0};
    dc  = '{32, 32, 32, 32}; e_dc = '{32, 0, 0, 0};
    s127  = '{127, 127, 127, 127, 127, 127, 127, 127};
    e127  = '{127, 0, 0, 0, 0, 0, 0, 0};
    zero8 = '{0, 0, 0, 0, 0, 0, 0, 0};
    // delayed impulse: bins 8*W8^k with floor rounding of the scaled product
    dimp  = '{0, 64, 0, 0, 0, 0, 0, 0};
    edr   = '{8, 5, 0, -6, -8, -6, 0, 6};
    edi   = '{0, -6, -8, -6, 0, 6, 8, 6};

    n_rst = 1'b0; rdy4 = 1'b0; inv4 = 1'b0; x4 = '0; rdy8 = 1'b0; x8 = '0;
    tick(); tick();
    check("rst_busy4", int'(busy4), 0);
    check("rst_valid4", int'(valid4), 0);
    check("rst_idx4", int'(idx4), 0);
    check("rst_y4_re", int'(y4_re), 0);
    check("rst_y4_im", int'(y4_im), 0);
    check("rst_ovr4", int'(ovr4), 0);
    check("rst_busy8", int'(busy8), 0);
    check("rst_valid8", int'(valid8), 0);
    check("rst_ovr8", int'(ovr8), 0);
    n_rst = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      push4(vt[v].er, vt[v].ei);
      load4(vt[v].x, vt[v].inv);
      drain();
    end
    check("d4_no_overrun_clean", int'(ovr4), 0);

    push8(e127, zero8);
    load8(s127);
    drain();
    push8(edr, edi);
    load8(dimp);
    drain();
    check("d8_no_overrun_clean", int'(ovr8), 0);

    // readyin held through COMPUTE/UNLOAD; second frame must load on LOAD re-entry
    push4(e16, zero4);
    push4(e_dc, zero4);
    load4_hold(imp);
    load4_hold(dc);
    rdy4 = 1'b0; x4 = '0;
    check("d4_overrun_set", int'(ovr4), 1);
    drain();
    check("d4_overrun_sticky", int'(ovr4), 1);

    // abort mid-COMPUTE; outputs clear without a clock edge
    load4(imp, 1'b0);
    tick(); tick();
    check("d4_busy_mid_compute", int'(busy4), 1);
    n_rst = 1'b0;
    #1;
    check("arst_busy4", int'(busy4), 0);
    check("arst_valid4", int'(valid4), 0);
    check("arst_y4_re", int'(y4_re), 0);
    check("arst_ovr4", int'(ovr4), 0);
    tick();
    n_rst = 1'b1;
    tick();
    push4(e16, zero4);
    load4(imp, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
